regfile_multiport_sb: RTL

//   Parametrised multi-port register file for the MIPS datapath. It provides NREAD

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rf_read_port.sv | 49 ++++
 rtl/regfile_multiport_sb.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, data type and address-width helper for the multi-port register file.
package regfile_pkg;

   localparam int unsigned RF_WIDTH = 32;
   localparam int unsigned RF_DEPTH = 32;

   typedef logic [RF_WIDTH-1:0] rf_data_t;

   // Address width for a given depth; never narrower than one bit.
   function automatic int unsigned rf_aw(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage select, same-cycle write bypass,
// busy masking and register-zero forcing.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = RF_WIDTH,
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned AW       = rf_aw(DEPTH)
) (
   input  logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] regs [DEPTH],
   input  logic [DEPTH-1:0] busy,
   input  logic             wr0_en,
   input  logic [AW-1:0]    wr0_addr,
   input  logic [WIDTH-1:0] wr0_data,
   input  logic             wr1_en,
   input  logic [AW-1:0]    wr1_addr,
   input  logic [WIDTH-1:0] wr1_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_busy
);

   logic w_hit0;
   logic w_hit1;

   assign w_hit0 = (BYPASS != 0) && wr0_en && (wr0_addr == rd_addr);
   assign w_hit1 = (BYPASS != 0) && wr1_en && (wr1_addr == rd_addr);

   // wr1 is checked last so it wins a collision with wr0; zero forcing overrides everything.
   always_comb begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
      if (w_hit0) begin
         rd_data = wr0_data;
         rd_busy = 1'b0;
      end
      if (w_hit1) begin
         rd_data = wr1_data;
         rd_busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_multiport_sb.sv
// Multi-port register file with two write ports, NREAD combinational read ports
// and a per-register scoreboard busy bit.
module regfile_multiport_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned WIDTH    = RF_WIDTH,
   parameter  int unsigned DEPTH    = RF_DEPTH,
   parameter  int unsigned NREAD    = 3,
   parameter  int unsigned ZERO_REG = 1,
   parameter  int unsigned BYPASS   = 1,
   localparam int unsigned AW       = rf_aw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   input  logic                   wr0_en,
   input  logic [AW-1:0]          wr0_addr,
   input  logic [WIDTH-1:0]       wr0_data,
   input  logic                   wr1_en,
   input  logic [AW-1:0]          wr1_addr,
   input  logic [WIDTH-1:0]       wr1_data,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;

   logic w_wr0_ok;
   logic w_wr1_ok;
   logic w_rsv_ok;

   // Register zero, when hardwired, swallows writes and reservations.
   assign w_wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
   assign w_wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
   assign w_rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Order matters: wr1 overrides wr0, and a new reservation overrides a write's busy clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_regs <= '{default: '0};
         r_busy <= '0;
      end else begin
         if (w_wr0_ok) begin
            r_regs[wr0_addr] <= wr0_data;
            r_busy[wr0_addr] <= 1'b0;
         end
         if (w_wr1_ok) begin
            r_regs[wr1_addr] <= wr1_data;
            r_busy[wr1_addr] <= 1'b0;
         end
         if (w_rsv_ok) begin
            r_busy[rsv_addr] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      rf_read_port #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS),
         .AW       (AW)
      ) u_port (
         .rd_addr  (rd_addr[g*AW +: AW]),
         .regs     (r_regs),
         .busy     (r_busy),
         .wr0_en   (wr0_en),
         .wr0_addr (wr0_addr),
         .wr0_data (wr0_data),
         .wr1_en   (wr1_en),
         .wr1_addr (wr1_addr),
         .wr1_data (wr1_data),
         .rd_data  (rd_data[g*WIDTH +: WIDTH]),
         .rd_busy  (rd_busy[g])
      );

      a_rd_addr_legal : assert property (@(posedge clk) disable iff (reset)
         (32'(rd_addr[g*AW +: AW]) < DEPTH));
   end

   a_wr_addr_legal : assert property (@(posedge clk) disable iff (reset)
      (!wr0_en || (32'(wr0_addr) < DEPTH)) &&
      (!wr1_en || (32'(wr1_addr) < DEPTH)) &&
      (!rsv_en || (32'(rsv_addr) < DEPTH)));

endmodule
